ldstr_read_port: RTL and testbench
==================================

LDSTR_READ_PORT -- requirements
Module: ldstr_read_port

Interface
REQ-001 Parameter N, default 8: data width in bits.
REQ-002 Parameter A, default 8: address width in bits.
REQ-003 Parameter TIMEOUT, default 16: maximum number of WAIT cycles before a read is aborted; legal range 2..31.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 clr  input  1  asynchronous, active-low reset; clr=0 forces reset state immediately, regardless of clk.
REQ-006 rd_req  input  1  read request from the pipeline, sampled only in IDLE.
REQ-007 rd_addr  input  A  read address, captured with rd_req.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 mem_req  output  1  registered request to memory.
REQ-010 mem_addr  output  A  registered address to memory.
REQ-011 mem_ack  input  1  memory response strobe; one cycle, qualifies mem_data.
REQ-012 mem_data  input  N  memory read data.
REQ-013 ld_data  output  N  registered load result.
REQ-014 ld_valid  output  1  ld_data/ld_err hold a result.
REQ-015 ld_take  input  1  consumer accepts the result.
REQ-016 ld_err  output  1  result was aborted by timeout.
REQ-017 rd_count  output  8  count of successfully completed reads.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, WAIT and HOLD.
REQ-019 IDLE with rd_req=1: next edge latches rd_addr into mem_addr, sets mem_req=1, clears the timeout counter, and enters WAIT. Latency: request in cycle 0, mem_req high in cycle 1.
REQ-020 IDLE with rd_req=0: no change of state or outputs.
REQ-021 WAIT with mem_ack=1: next edge loads ld_data with mem_data, sets ld_valid=1, ld_err=0, clears mem_req, increments rd_count, and enters HOLD.
REQ-022 WAIT with mem_ack=0: timeout counter increments by 1 per cycle; mem_req and mem_addr are held stable.
REQ-023 WAIT with mem_ack=0 and the counter at TIMEOUT-1 (TIMEOUT cycles spent in WAIT): next edge clears mem_req, sets ld_data=0, ld_err=1, ld_valid=1, leaves rd_count unchanged, and enters HOLD.
REQ-024 mem_ack in the same cycle as the timeout condition: ack wins and the REQ-021 action applies.
REQ-025 HOLD: ld_valid, ld_data and ld_err are held stable until ld_take=1.
REQ-026 HOLD with ld_take=1: next edge clears ld_valid and ld_err and enters IDLE; ld_data keeps its last value.
REQ-027 rd_req is ignored in WAIT and HOLD; a request is not queued.
REQ-028 mem_ack is ignored in IDLE and HOLD.
REQ-029 ld_take is ignored when ld_valid=0.
REQ-030 rd_count wraps from 255 to 0 with no flag.
REQ-031 The earliest new mem_req after a take occurs two cycles after ld_take: one edge to reach IDLE, one edge to accept rd_req.

Reset
REQ-032 clr=0 SHALL force, asynchronously: state=IDLE, mem_req=0, mem_addr=0, ld_data=0, ld_valid=0, ld_err=0, rd_count=0, timeout counter=0, busy=0.
REQ-033 clr asserted mid-operation (WAIT or HOLD) SHALL abandon the transaction; after clr returns high, the block waits in IDLE for a new rd_req.
REQ-034 The block SHALL assert no output other than the reset values while clr=0.

Verification
REQ-035 Basic read: rd_req=1, rd_addr=0x3C; mem_ack with mem_data=0xA5 three cycles after mem_req rises -> mem_addr=0x3C; ld_data=0xA5, ld_valid=1, ld_err=0, rd_count=1; ld_take -> IDLE, busy=0.
REQ-036 Timeout: TIMEOUT=16, mem_ack held low -> mem_req drops after 16 WAIT cycles; ld_err=1, ld_valid=1, ld_data=0x00, rd_count unchanged.
REQ-037 Ack on the timeout cycle: mem_ack=1 with mem_data=0x5A in WAIT cycle 16 -> ld_err=0, ld_data=0x5A, rd_count incremented.
REQ-038 Ignored inputs: rd_req pulses during WAIT and HOLD, stray mem_ack in IDLE and HOLD, ld_take in IDLE -> no state change, no extra mem_req, rd_count unchanged.
REQ-039 Reset mid-WAIT: clr=0 asserted between clock edges while mem_req=1 -> all outputs drop to reset values before the next clk edge; after release, a new read completes normally.
REQ-040 Wrap: 256 back-to-back successful reads -> rd_count returns to 0x00; ld_valid timing matches REQ-031 throughout.

Source files
------------

// File: rtl/ldstr_read_port.sv
// Single-outstanding load read port: issues one registered memory request,
// waits for an ack or a timeout, then holds the result until consumed.
module ldstr_read_port #(
    parameter int N       = 8,
    parameter int A       = 8,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         rd_req,
    input  logic [A-1:0] rd_addr,
    output logic         busy,
    output logic         mem_req,
    output logic [A-1:0] mem_addr,
    input  logic         mem_ack,
    input  logic [N-1:0] mem_data,
    output logic [N-1:0] ld_data,
    output logic         ld_valid,
    input  logic         ld_take,
    output logic         ld_err,
    output logic [7:0]   rd_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    // Counter value seen during the last permitted WAIT cycle.
    localparam logic [4:0] TMO_LAST = 5'(TIMEOUT - 1);

    logic [1:0] state;
    logic [4:0] tmo_cnt;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            tmo_cnt  <= 5'd0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            ld_data  <= '0;
            ld_valid <= 1'b0;
            ld_err   <= 1'b0;
            rd_count <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req) begin
                        mem_addr <= rd_addr;
                        mem_req  <= 1'b1;
                        tmo_cnt  <= 5'd0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // An ack arriving on the final timeout cycle still completes the read.
                    if (mem_ack) begin
                        ld_data  <= mem_data;
                        ld_valid <= 1'b1;
                        ld_err   <= 1'b0;
                        mem_req  <= 1'b0;
                        rd_count <= rd_count + 8'd1;
                        state    <= HOLD;
                    end else if (tmo_cnt == TMO_LAST) begin
                        ld_data  <= '0;
                        ld_valid <= 1'b1;
                        ld_err   <= 1'b1;
                        mem_req  <= 1'b0;
                        state    <= HOLD;
                    end else begin
                        tmo_cnt <= tmo_cnt + 5'd1;
                    end
                end
                HOLD: begin
                    if (ld_take) begin
                        ld_valid <= 1'b0;
                        ld_err   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldstr_read_port.sv
// Bench for ldstr_read_port: directed vector table, hand-written corner
// sequences and randomized traffic against a transaction-level model.
module tb_ldstr_read_port;

    localparam int N       = 8;
    localparam int A       = 8;
    localparam int TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         clr;
    logic         rd_req;
    logic [A-1:0] rd_addr;
    logic         busy;
    logic         mem_req;
    logic [A-1:0] mem_addr;
    logic         mem_ack;
    logic [N-1:0] mem_data;
    logic [N-1:0] ld_data;
    logic         ld_valid;
    logic         ld_take;
    logic         ld_err;
    logic [7:0]   rd_count;

    always #5 clk = ~clk;

    ldstr_read_port #(.N(N), .A(A), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .clr(clr), .rd_req(rd_req), .rd_addr(rd_addr), .busy(busy),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .ld_data(ld_data), .ld_valid(ld_valid), .ld_take(ld_take), .ld_err(ld_err),
        .rd_count(rd_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: a read is either in flight (counting waited
    // cycles), delivered and awaiting take, or absent.
    bit           m_in_flight;
    bit           m_has_result;
    int           m_waited;
    logic [A-1:0] m_addr;
    logic         m_mreq;
    logic [N-1:0] m_data;
    logic         m_valid;
    logic         m_err;
    int           m_count;

    task automatic model_reset();
        m_in_flight  = 0;
        m_has_result = 0;
        m_waited     = 0;
        m_addr       = '0;
        m_mreq       = 1'b0;
        m_data       = '0;
        m_valid      = 1'b0;
        m_err        = 1'b0;
        m_count      = 0;
    endtask

    task automatic model_edge();
        if (m_has_result) begin
            if (ld_take) begin
                m_has_result = 0;
                m_valid      = 1'b0;
                m_err        = 1'b0;
            end
        end else if (m_in_flight) begin
            m_waited++;
            if (mem_ack) begin
                m_data       = mem_data;
                m_valid      = 1'b1;
                m_err        = 1'b0;
                m_mreq       = 1'b0;
                m_count      = (m_count + 1) % 256;
                m_in_flight  = 0;
                m_has_result = 1;
            end else if (m_waited == TIMEOUT) begin
                m_data       = '0;
                m_valid      = 1'b1;
                m_err        = 1'b1;
                m_mreq       = 1'b0;
                m_in_flight  = 0;
                m_has_result = 1;
            end
        end else if (rd_req) begin
            m_addr      = rd_addr;
            m_mreq      = 1'b1;
            m_in_flight = 1;
            m_waited    = 0;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".busy"},     32'(busy),     32'(m_in_flight || m_has_result));
        check({tag, ".mem_req"},  32'(mem_req),  32'(m_mreq));
        check({tag, ".mem_addr"}, 32'(mem_addr), 32'(m_addr));
        check({tag, ".ld_data"},  32'(ld_data),  32'(m_data));
        check({tag, ".ld_valid"}, 32'(ld_valid), 32'(m_valid));
        check({tag, ".ld_err"},   32'(ld_err),   32'(m_err));
        check({tag, ".rd_count"}, 32'(rd_count), 32'(m_count));
    endtask

    // Inputs are set at the negedge; one call consumes one rising edge.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (clr) model_edge();
        else     model_reset();
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic quiet_inputs();
        rd_req   = 1'b0;
        rd_addr  = '0;
        mem_ack  = 1'b0;
        mem_data = '0;
        ld_take  = 1'b0;
    endtask

    task automatic do_reset();
        clr = 1'b0;
        quiet_inputs();
        cycle("rst");
        cycle("rst");
        clr = 1'b1;
    endtask

    typedef struct {
        logic       req;
        logic [7:0] addr;
        logic       ack;
        logic [7:0] mdata;
        logic       take;
        logic       e_busy;
        logic       e_mreq;
        logic [7:0] e_maddr;
        logic       e_vld;
        logic       e_err;
        logic [7:0] e_ldata;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tbl [11];
    logic [7:0] saved_cnt;

    initial begin
        // Basic read of 0x3C, ignored inputs in HOLD/IDLE/WAIT, then a second read.
        tbl[0]  = '{1'b1, 8'h3C, 1'b0, 8'h00, 1'b0,  1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 8'd0};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0,  1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 8'd0};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0,  1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 8'd0};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 8'hA5, 1'b0,  1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 8'hA5, 8'd1};
        tbl[4]  = '{1'b1, 8'h99, 1'b1, 8'h77, 1'b0,  1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 8'hA5, 8'd1};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1,  1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'hA5, 8'd1};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 8'h66, 1'b1,  1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'hA5, 8'd1};
        tbl[7]  = '{1'b1, 8'h10, 1'b0, 8'h00, 1'b0,  1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 8'hA5, 8'd1};
        tbl[8]  = '{1'b1, 8'h20, 1'b0, 8'h00, 1'b1,  1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 8'hA5, 8'd1};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 8'hC3, 1'b0,  1'b1, 1'b0, 8'h10, 1'b1, 1'b0, 8'hC3, 8'd2};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1,  1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 8'hC3, 8'd2};

        model_reset();
        clr = 1'b0;
        quiet_inputs();
        @(negedge clk);
        do_reset();
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.mem_req", 32'(mem_req), 32'd0);
        check("reset.rd_count", 32'(rd_count), 32'd0);

        for (int i = 0; i < 11; i++) begin
            rd_req   = tbl[i].req;
            rd_addr  = tbl[i].addr;
            mem_ack  = tbl[i].ack;
            mem_data = tbl[i].mdata;
            ld_take  = tbl[i].take;
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check($sformatf("vec%0d.busy", i),     32'(busy),     32'(tbl[i].e_busy));
            check($sformatf("vec%0d.mem_req", i),  32'(mem_req),  32'(tbl[i].e_mreq));
            check($sformatf("vec%0d.mem_addr", i), 32'(mem_addr), 32'(tbl[i].e_maddr));
            check($sformatf("vec%0d.ld_valid", i), 32'(ld_valid), 32'(tbl[i].e_vld));
            check($sformatf("vec%0d.ld_err", i),   32'(ld_err),   32'(tbl[i].e_err));
            check($sformatf("vec%0d.ld_data", i),  32'(ld_data),  32'(tbl[i].e_ldata));
            check($sformatf("vec%0d.rd_count", i), 32'(rd_count), 32'(tbl[i].e_cnt));
        end
        quiet_inputs();

        // Timeout: mem_req stays high for exactly TIMEOUT WAIT cycles.
        saved_cnt = rd_count;
        rd_req = 1'b1; rd_addr = 8'h81;
        cycle("to_req");
        rd_req = 1'b0;
        for (int i = 1; i < TIMEOUT; i++) cycle("to_wait");
        check("to.mem_req_last_wait", 32'(mem_req), 32'd1);
        cycle("to_abort");
        check("to.mem_req", 32'(mem_req), 32'd0);
        check("to.ld_err", 32'(ld_err), 32'd1);
        check("to.ld_valid", 32'(ld_valid), 32'd1);
        check("to.ld_data", 32'(ld_data), 32'd0);
        check("to.rd_count", 32'(rd_count), 32'(saved_cnt));
        ld_take = 1'b1;
        cycle("to_take");
        ld_take = 1'b0;

        // Ack arriving on WAIT cycle TIMEOUT wins over the abort.
        rd_req = 1'b1; rd_addr = 8'h82;
        cycle("ackto_req");
        rd_req = 1'b0;
        for (int i = 1; i < TIMEOUT; i++) cycle("ackto_wait");
        mem_ack = 1'b1; mem_data = 8'h5A;
        cycle("ackto_ack");
        mem_ack = 1'b0;
        check("ackto.ld_err", 32'(ld_err), 32'd0);
        check("ackto.ld_data", 32'(ld_data), 32'h5A);
        check("ackto.rd_count", 32'(rd_count), 32'(saved_cnt + 8'd1));
        ld_take = 1'b1;
        cycle("ackto_take");
        ld_take = 1'b0;

        // Asynchronous reset between edges while a read is outstanding.
        rd_req = 1'b1; rd_addr = 8'h44;
        cycle("arst_req");
        rd_req = 1'b0;
        cycle("arst_wait");
        check("arst.pre_mem_req", 32'(mem_req), 32'd1);
        #2 clr = 1'b0;
        #1;
        check("arst.busy", 32'(busy), 32'd0);
        check("arst.mem_req", 32'(mem_req), 32'd0);
        check("arst.mem_addr", 32'(mem_addr), 32'd0);
        check("arst.rd_count", 32'(rd_count), 32'd0);
        model_reset();
        cycle("arst_hold");
        clr = 1'b1;
        rd_req = 1'b1; rd_addr = 8'h55;
        cycle("arst_new_req");
        rd_req = 1'b0;
        mem_ack = 1'b1; mem_data = 8'h99;
        cycle("arst_new_ack");
        mem_ack = 1'b0;
        check("arst.new_data", 32'(ld_data), 32'h99);
        check("arst.new_count", 32'(rd_count), 32'd1);
        ld_take = 1'b1;
        cycle("arst_new_take");
        ld_take = 1'b0;

        // 256 back-to-back reads with rd_req held through the take.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            rd_req = 1'b1; rd_addr = 8'(i); ld_take = 1'b0;
            cycle("wrap_req");
            rd_req = 1'b0; mem_ack = 1'b1; mem_data = 8'($urandom);
            cycle("wrap_ack");
            mem_ack = 1'b0; ld_take = 1'b1; rd_req = 1'b1;
            cycle("wrap_take");
        end
        quiet_inputs();
        check("wrap.rd_count", 32'(rd_count), 32'd0);

        // Randomized traffic, including occasional reset pulses.
        for (int i = 0; i < 3000; i++) begin
            clr      = ($urandom_range(0, 199) != 0);
            rd_req   = ($urandom_range(0, 2) == 0);
            rd_addr  = 8'($urandom);
            mem_ack  = ($urandom_range(0, 9) == 0);
            mem_data = 8'($urandom);
            ld_take  = ($urandom_range(0, 2) == 0);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
